// File: rtl/mem_arbiter_if.sv
// Bundle of the requester-side and memory-side handshakes of the arbiter.
// master = the arbiter itself, slave = the requesters plus memory around it.
interface mem_arbiter_if #(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [NUM_CH-1:0]          req_valid;
   logic [NUM_CH-1:0]          req_ready;
   logic [NUM_CH*ADDR_W-1:0]   req_addr;
   logic [NUM_CH-1:0]          req_wen;
   logic [NUM_CH*DATA_W-1:0]   req_wdata;
   logic [NUM_CH*DATA_W/8-1:0] req_wmask;
   logic [NUM_CH-1:0]          resp_valid;
   logic [DATA_W-1:0]          resp_rdata;
   logic                       resp_err;
   logic                       mem_req_valid;
   logic                       mem_req_ready;
   logic [ADDR_W-1:0]          mem_addr;
   logic                       mem_wen;
   logic [DATA_W-1:0]          mem_wdata;
   logic [DATA_W/8-1:0]        mem_wmask;
   logic                       mem_resp_valid;
   logic [DATA_W-1:0]          mem_rdata;

   modport master (
      input  req_valid, req_addr, req_wen, req_wdata, req_wmask,
             mem_req_ready, mem_resp_valid, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
             mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
   );

   modport slave (
      output req_valid, req_addr, req_wen, req_wdata, req_wmask,
             mem_req_ready, mem_resp_valid, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter putting NUM_CH requesters onto one memory port, one
// transaction at a time, with a response watchdog for a silent memory.
module mem_arbiter #(
   parameter int NUM_CH  = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input logic           clk,
   input logic           rst,
   mem_arbiter_if.master bus
);
   localparam int MW = DATA_W / 8;
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       rr_q, rr_d, gnt_q, gnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wen_q, wen_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [MW-1:0]       wmask_q, wmask_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic [NUM_CH-1:0]   resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;

   logic                found;
   logic [CW-1:0]       pick, idx, rr_nxt;
   logic [ADDR_W-1:0]   ch_addr  [NUM_CH];
   logic [DATA_W-1:0]   ch_wdata [NUM_CH];
   logic [MW-1:0]       ch_wmask [NUM_CH];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
      assign ch_addr[i]  = bus.req_addr[i*ADDR_W +: ADDR_W];
      assign ch_wdata[i] = bus.req_wdata[i*DATA_W +: DATA_W];
      assign ch_wmask[i] = bus.req_wmask[i*MW +: MW];
   end

   // Pointer after the channel just served; constant 0 when NUM_CH=1.
   assign rr_nxt = CW'((int'(gnt_q) + 1) % NUM_CH);

   // First valid channel, searching upward from the round-robin pointer.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = CW'((int'(rr_q) + i) % NUM_CH);
         if (!found && bus.req_valid[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   // Next-state logic and the combinational grant.
   always_comb begin
      state_d       = state_q;
      rr_d          = rr_q;
      gnt_d         = gnt_q;
      addr_d        = addr_q;
      wen_d         = wen_q;
      wdata_d       = wdata_q;
      wmask_d       = wmask_q;
      timer_d       = timer_q;
      resp_valid_d  = '0;
      rdata_d       = rdata_q;
      err_d         = err_q;
      bus.req_ready = '0;
      case (state_q)
         IDLE: begin
            // Gated by rst so no requester sees a grant that reset discards.
            if (found && !rst) begin
               bus.req_ready[pick] = 1'b1;
               gnt_d   = pick;
               addr_d  = ch_addr[pick];
               wen_d   = bus.req_wen[pick];
               wdata_d = ch_wdata[pick];
               wmask_d = ch_wmask[pick];
               state_d = REQ;
            end
         end
         REQ: begin
            if (bus.mem_req_ready) begin
               timer_d = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (bus.mem_resp_valid) begin
               resp_valid_d[gnt_q] = 1'b1;
               rdata_d = bus.mem_rdata;
               err_d   = 1'b0;
               rr_d    = rr_nxt;
               state_d = IDLE;
            end else if (TIMEOUT != 0 && timer_q == TW'(TIMEOUT - 1)) begin
               resp_valid_d[gnt_q] = 1'b1;
               rdata_d = '0;
               err_d   = 1'b1;
               rr_d    = rr_nxt;
               state_d = IDLE;
            end else if (timer_q != '1) begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any transaction in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         rr_q         <= '0;
         gnt_q        <= '0;
         addr_q       <= '0;
         wen_q        <= 1'b0;
         wdata_q      <= '0;
         wmask_q      <= '0;
         timer_q      <= '0;
         resp_valid_q <= '0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_q         <= rr_d;
         gnt_q        <= gnt_d;
         addr_q       <= addr_d;
         wen_q        <= wen_d;
         wdata_q      <= wdata_d;
         wmask_q      <= wmask_d;
         timer_q      <= timer_d;
         resp_valid_q <= resp_valid_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
      end
   end

   assign bus.mem_req_valid = (state_q == REQ);
   assign bus.mem_addr      = addr_q;
   assign bus.mem_wen       = wen_q;
   assign bus.mem_wdata     = wdata_q;
   assign bus.mem_wmask     = wmask_q;
   assign bus.resp_valid    = resp_valid_q;
   assign bus.resp_rdata    = rdata_q;
   assign bus.resp_err      = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a 2-channel instance (watchdog 8) driven by directed
// and random traffic against a transaction-level model, and a 3-channel
// instance for round-robin order.
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if #(.NUM_CH(2), .ADDR_W(AW), .DATA_W(DW)) b0 ();
   mem_arbiter_if #(.NUM_CH(3), .ADDR_W(AW), .DATA_W(DW)) b1 ();

   mem_arbiter #(.NUM_CH(2), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8))
      dut0 (.clk(clk), .rst(rst), .bus(b0.master));
   mem_arbiter #(.NUM_CH(3), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16))
      dut1 (.clk(clk), .rst(rst), .bus(b1.master));

   int checks = 0;
   int failures = 0;

   // Requester-side request registers for the 2-channel instance.
   logic [AW-1:0] r_addr  [2];
   logic [DW-1:0] r_wdata [2];
   logic [3:0]    r_wmask [2];
   logic [1:0]    r_wen;
   assign b0.req_addr  = {r_addr[1], r_addr[0]};
   assign b0.req_wdata = {r_wdata[1], r_wdata[0]};
   assign b0.req_wmask = {r_wmask[1], r_wmask[0]};
   assign b0.req_wen   = r_wen;

   // Transaction model: one outstanding transaction, round-robin pointer.
   bit            busy = 0;
   int            g = 0, ptr = 0, busy_cyc = 0;
   logic [AW-1:0] e_addr = '0;
   logic [DW-1:0] e_wdata = '0;
   logic [3:0]    e_wmask = '0;
   logic          e_wen = 1'b0;
   bit            expect_err = 0;
   logic [1:0]    clr = '0;
   int            cyc = 0, grant_cyc = 0, resp_cyc = 0;
   int            n_grant = 0, n_resp = 0, n_down = 0, n_reqcyc = 0;
   int            gq[$];

   // Memory behaviour knobs.
   int rdy_fix = -1, rdy_max = 0, resp_max = 0;
   bit dead = 0, stray = 0;

   function automatic logic [DW-1:0] f(input logic [AW-1:0] a);
      return a ^ 32'h5EAD_BEEB;
   endfunction

   function automatic int rr_pick(input logic [7:0] v, input int p, input int n);
      for (int i = 0; i < n; i++)
         if (v[3'((p + i) % n)]) return (p + i) % n;
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string p);
      chk({p, "_req_ready"}, b0.req_ready, 0);
      chk({p, "_resp_valid"}, b0.resp_valid, 0);
      chk({p, "_resp_rdata"}, b0.resp_rdata, 0);
      chk({p, "_resp_err"}, b0.resp_err, 0);
      chk({p, "_mem_req_valid"}, b0.mem_req_valid, 0);
      chk({p, "_mem_addr"}, b0.mem_addr, 0);
      chk({p, "_mem_wen"}, b0.mem_wen, 0);
      chk({p, "_mem_wdata"}, b0.mem_wdata, 0);
      chk({p, "_mem_wmask"}, b0.mem_wmask, 0);
   endtask

   task automatic set_req(input int c, input logic [AW-1:0] a, input logic w,
                          input logic [DW-1:0] d, input logic [3:0] m);
      r_addr[1'(c)] = a;
      r_wen[1'(c)] = w;
      r_wdata[1'(c)] = d;
      r_wmask[1'(c)] = m;
      b0.req_valid[1'(c)] = 1'b1;
   endtask

   // Next negedge; requests granted last cycle are withdrawn now.
   task automatic tick_edge();
      @(negedge clk);
      b0.req_valid = b0.req_valid & ~clr;
      clr = '0;
   endtask

   // Compare one cycle of DUT behaviour with the transaction model.
   task automatic observe();
      int e;
      #1;
      cyc++;
      if (b0.mem_req_valid === 1'b1) n_reqcyc++;
      if (b0.resp_valid !== 2'b00) begin
         chk("resp_expected", busy, 1);
         chk("resp_ch", b0.resp_valid, 64'd1 << g);
         chk("resp_err", b0.resp_err, expect_err);
         chk("resp_rdata", b0.resp_rdata, expect_err ? 64'd0 : 64'(f(e_addr)));
         busy = 0;
         ptr = (g + 1) % 2;
         n_resp++;
         resp_cyc = cyc;
      end
      e = busy ? -1 : rr_pick({6'b0, b0.req_valid}, ptr, 2);
      chk("req_ready", b0.req_ready, (e < 0) ? 64'd0 : (64'd1 << e));
      if (e >= 0) begin
         busy = 1;
         g = e;
         e_addr = r_addr[1'(e)];
         e_wen = r_wen[1'(e)];
         e_wdata = r_wdata[1'(e)];
         e_wmask = r_wmask[1'(e)];
         grant_cyc = cyc;
         n_grant++;
         gq.push_back(e);
         busy_cyc = 0;
         clr[1'(e)] = 1'b1;
      end else if (busy) begin
         busy_cyc++;
         if (busy_cyc > 40) begin
            checks++;
            failures++;
            $error("FAIL resp_watchdog observed=no_response expected=response_within_40_cycles");
            busy = 0;
         end
      end
   endtask

   task automatic run(input int n);
      repeat (n) begin
         tick_edge();
         observe();
      end
   endtask

   // Memory model for the 2-channel instance; also checks the downstream
   // request against the transaction granted upstream.
   initial begin
      int dly;
      logic [AW-1:0] a;
      b0.mem_req_ready = 1'b0;
      b0.mem_resp_valid = 1'b0;
      b0.mem_rdata = '0;
      forever begin
         @(negedge clk);
         b0.mem_req_ready = 1'b0;
         b0.mem_resp_valid = 1'b0;
         if (stray) begin
            b0.mem_resp_valid = 1'b1;
            b0.mem_rdata = 32'hBAD0_BAD0;
            stray = 0;
         end else if (b0.mem_req_valid === 1'b1 && !rst) begin
            dly = (rdy_fix >= 0) ? rdy_fix : int'($urandom_range(0, rdy_max));
            for (int k = 0; k <= dly; k++) begin
               if (k > 0) @(negedge clk);
               chk("dn_valid", b0.mem_req_valid, 1);
               chk("dn_addr", b0.mem_addr, e_addr);
               chk("dn_wen", b0.mem_wen, e_wen);
               chk("dn_wdata", b0.mem_wdata, e_wdata);
               chk("dn_wmask", b0.mem_wmask, e_wmask);
               b0.mem_req_ready = (k == dly);
            end
            a = b0.mem_addr;
            n_down++;
            @(negedge clk);
            b0.mem_req_ready = 1'b0;
            if (!dead) begin
               repeat ($urandom_range(0, resp_max)) @(negedge clk);
               b0.mem_resp_valid = 1'b1;
               b0.mem_rdata = f(a);
            end
         end
      end
   end

   // Ideal memory for the 3-channel instance: always ready, answers in the
   // first cycle after the request is accepted.
   initial begin
      logic          pend;
      logic [AW-1:0] pa;
      pend = 1'b0;
      pa = '0;
      b1.mem_req_ready = 1'b1;
      b1.mem_resp_valid = 1'b0;
      b1.mem_rdata = '0;
      forever begin
         @(negedge clk);
         b1.mem_resp_valid = pend;
         b1.mem_rdata = f(pa);
         pend = b1.mem_req_valid;
         pa = b1.mem_addr;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=still_running expected=finished");
      $fatal(1, "simulation time bound exceeded");
   end

   initial begin
      int r0, d0, g0, q0;
      logic [2:0] gseq[$];
      logic [2:0] rseq[$];
      logic [2:0] ex6 [4];
      logic [DW-1:0] rd6;
      ex6 = '{3'b001, 3'b010, 3'b100, 3'b001};
      rd6 = '0;
      for (int c = 0; c < 2; c++) begin
         r_addr[1'(c)] = '0; r_wdata[1'(c)] = '0; r_wmask[1'(c)] = '0;
      end
      r_wen = '0;
      b1.req_addr = {32'h3000_0008, 32'h3000_0004, 32'h3000_0000};
      b1.req_wen = '0;
      b1.req_wdata = '0;
      b1.req_wmask = '0;
      b1.req_valid = '0;

      // Reset: everything zero, no grant even with requests pending.
      b0.req_valid = 2'b11;
      repeat (3) @(negedge clk);
      #1 chk_zero("rst");
      @(negedge clk);
      b0.req_valid = 2'b00;
      rst = 1'b0;

      // 1: single read on ch1, ideal memory, latency 3.
      tick_edge();
      set_req(1, 32'h8000_0004, 1'b0, 32'h0, 4'hF);
      observe();
      chk("t1_ready", b0.req_ready, 2'b10);
      tick_edge();
      observe();
      chk("t1_mreq", b0.mem_req_valid, 1);
      chk("t1_maddr", b0.mem_addr, 32'h8000_0004);
      run(2);
      chk("t1_latency", resp_cyc - grant_cyc, 3);
      chk("t1_rdata", b0.resp_rdata, 32'hDEAD_BEEF);
      chk("t1_err", b0.resp_err, 0);

      // 2: both channels continuously requesting -> alternate grants.
      q0 = gq.size();
      repeat (15) begin
         tick_edge();
         for (int c = 0; c < 2; c++)
            if (!b0.req_valid[1'(c)])
               set_req(c, 32'h1000_0000 + 32'(c * 16 + cyc * 4), 1'b0, 32'h0, 4'hF);
         observe();
      end
      chk("t2_count", (gq.size() - q0) >= 4, 1);
      for (int k = 0; k < 4; k++)
         chk("t2_order", (q0 + k < gq.size()) ? gq[q0 + k] : -1, k % 2);
      run(8);

      // 3: write with mem_req_ready held low for 5 cycles.
      rdy_fix = 5;
      d0 = n_down;
      r0 = n_reqcyc;
      tick_edge();
      set_req(1, 32'h2000_0010, 1'b1, 32'h1122_3344, 4'b0101);
      observe();
      run(12);
      chk("t3_downstream", n_down - d0, 1);
      chk("t3_req_cycles", n_reqcyc - r0, 6);
      rdy_fix = -1;

      // 4: dead memory -> error response; WAIT spans timer 0..7 starting
      // two cycles after the grant, the error pulse follows one cycle later.
      dead = 1;
      expect_err = 1;
      tick_edge();
      set_req(0, 32'h0000_0040, 1'b0, 32'h0, 4'hF);
      observe();
      run(12);
      chk("t4_latency", resp_cyc - grant_cyc, 10);
      dead = 0;
      expect_err = 0;
      r0 = n_resp;
      tick_edge();
      set_req(1, 32'h0000_0080, 1'b0, 32'h0, 4'hF);
      observe();
      run(5);
      chk("t4_next_served", n_resp - r0, 1);

      // 5: stray response in IDLE is ignored; reset in WAIT aborts.
      r0 = n_resp;
      stray = 1;
      run(5);
      chk("t5_stray", n_resp - r0, 0);
      tick_edge();
      set_req(0, 32'h0000_00C0, 1'b0, 32'h0, 4'hF);
      observe();
      run(5);
      chk("t5_after_stray", n_resp - r0, 1);
      dead = 1;
      tick_edge();
      set_req(0, 32'h4000_0000, 1'b0, 32'h0, 4'hF);
      observe();
      run(2);
      @(negedge clk);
      rst = 1'b1;
      b0.req_valid = 2'b11;
      #1 chk("t5_rst_ready", b0.req_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      b0.req_valid = 2'b00;
      #1 chk_zero("t5");
      busy = 0; ptr = 0; dead = 0; clr = '0;
      run(4);
      tick_edge();
      set_req(0, 32'h0000_0100, 1'b0, 32'h0, 4'hF);
      set_req(1, 32'h0000_0104, 1'b0, 32'h0, 4'hF);
      observe();
      chk("t5_ptr", b0.req_ready, 2'b01);
      run(8);

      // 6: three channels: ch2 alone, then all three -> 0,1,2.
      @(negedge clk);
      b1.req_valid = 3'b100;
      #1 chk("t6_alone", b1.req_ready, 3'b100);
      @(negedge clk);
      b1.req_valid = 3'b111;
      repeat (14) begin
         @(negedge clk);
         #1;
         if (b1.req_ready != 3'b000) gseq.push_back(b1.req_ready);
         if (b1.resp_valid != 3'b000) begin
            if (rseq.size() == 0) rd6 = b1.resp_rdata;
            rseq.push_back(b1.resp_valid);
         end
      end
      b1.req_valid = 3'b000;
      for (int k = 0; k < 4; k++)
         chk("t6_order", (k < gseq.size()) ? gseq[k] : 3'bxxx, ex6[k]);
      chk("t6_first_resp", (rseq.size() > 0) ? rseq[0] : 3'bxxx, 3'b100);
      chk("t6_first_rdata", rd6, f(32'h3000_0008));

      // Random traffic with random memory delays.
      rdy_max = 3;
      resp_max = 3;
      g0 = n_grant;
      r0 = n_resp;
      d0 = n_down;
      repeat (500) begin
         tick_edge();
         for (int c = 0; c < 2; c++) begin
            if (!b0.req_valid[1'(c)]) begin
               if ($urandom_range(0, 99) < 50)
                  set_req(c, $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
                          $urandom, 4'($urandom));
            end else if ($urandom_range(0, 29) == 0) begin
               b0.req_valid[1'(c)] = 1'b0;
            end
         end
         observe();
      end
      run(30);
      chk("rand_resp_count", n_resp - r0, n_grant - g0);
      chk("rand_down_count", n_down - d0, n_grant - g0);
      chk("rand_drained", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
